// File: rtl/ntt_batch_frontend.sv
// Streaming front end for the NTT core: job FIFO, beat-to-row assembly, core sequencing, row unload.
// Define NTT_FE_RUN_CNT_EN to count START/RUN cycles into run_cycles (otherwise run_cycles is 0).
module ntt_batch_frontend #(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 257,
    parameter int LANES      = 8,
    parameter int ROWS       = 1,
    parameter int JOB_DEPTH  = 4,
    parameter int NUM_MODULI = 40,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [5:0]              job_mod_idx,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*LANES-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*LANES-1:0]  out_data,
    output logic                    out_last,
    output logic                    core_start,
    output logic [5:0]              core_mod_idx,
    output logic                    core_mem_write,
    output logic                    core_mem_read,
    output logic [8*SIZE-1:0]       core_mem_addr,
    output logic [WIDTH*SIZE-1:0]   core_din,
    input  logic [WIDTH*SIZE-1:0]   core_dout,
    input  logic                    core_done,
    output logic                    busy,
    output logic                    err_mod_idx,
    output logic [31:0]             run_cycles
);
    localparam int BEATS = (SIZE + LANES - 1) / LANES;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int AW    = $clog2(JOB_DEPTH);
    localparam int LW    = $clog2(RD_LAT + 2);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, START, RUN, READ, STREAM} state_t;

    state_t                  state;
    logic [5:0]              mod_idx;
    logic [8:0]              row;
    logic [8:0]              row_inc;
    logic                    more_rows;
    logic [BW-1:0]           beat;
    logic [LW-1:0]           rd_cnt;
    logic [WIDTH*SIZE-1:0]   staging;
    logic [WIDTH*SIZE-1:0]   unload;
    logic                    write_q, read_q, start_q, valid_q;

    logic [5:0]              fifo_mem [JOB_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr;
    logic                    fifo_empty, fifo_full, idx_ok, push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign idx_ok     = 32'(job_mod_idx) < NUM_MODULI;
    assign job_ready  = !fifo_full;
    assign push       = job_valid && job_ready && idx_ok;
    assign pop        = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_mod_idx <= 1'b0;
            for (int i = 0; i < JOB_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            // Rejected jobs still complete the handshake; they only raise the error pulse.
            err_mod_idx <= job_valid && job_ready && !idx_ok;
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= job_mod_idx;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign row_inc   = row + 9'd1;
    assign more_rows = 32'(row_inc) < ROWS;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mod_idx <= '0;
            row     <= '0;
            beat    <= '0;
            rd_cnt  <= '0;
            staging <= '0;
            unload  <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            start_q <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    mod_idx <= fifo_mem[rd_ptr[AW-1:0]];
                    row     <= '0;
                    beat    <= '0;
                    state   <= LOAD;
                end
                LOAD: if (in_valid) begin
                    // Padding lanes of the final beat fall past SIZE and are dropped here.
                    for (int l = 0; l < LANES; l++)
                        if (int'(beat) * LANES + l < SIZE)
                            staging[(int'(beat) * LANES + l) * WIDTH +: WIDTH] <= in_data[l*WIDTH +: WIDTH];
                    if (beat == LAST_BEAT) begin
                        beat    <= '0;
                        write_q <= 1'b1;
                        state   <= WRITE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                WRITE: begin
                    row <= row_inc;
                    if (more_rows) begin
                        state <= LOAD;
                    end else begin
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: state <= RUN;
                RUN: if (core_done) begin
                    row    <= '0;
                    rd_cnt <= '0;
                    read_q <= 1'b1;
                    state  <= READ;
                end
                READ: if (32'(rd_cnt) == RD_LAT) begin
                    unload  <= core_dout;
                    beat    <= '0;
                    valid_q <= 1'b1;
                    state   <= STREAM;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                STREAM: if (out_ready) begin
                    if (beat == LAST_BEAT) begin
                        beat    <= '0;
                        valid_q <= 1'b0;
                        if (more_rows) begin
                            row    <= row_inc;
                            rd_cnt <= '0;
                            read_q <= 1'b1;
                            state  <= READ;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int l = 0; l < LANES; l++)
            if (int'(beat) * LANES + l < SIZE)
                out_data[l*WIDTH +: WIDTH] = unload[(int'(beat) * LANES + l) * WIDTH +: WIDTH];
    end

    assign in_ready       = (state == LOAD);
    assign out_valid      = valid_q;
    assign out_last       = valid_q && (beat == LAST_BEAT) && !more_rows;
    assign core_start     = start_q;
    assign core_mod_idx   = start_q ? mod_idx : 6'd0;
    assign core_mem_write = write_q;
    assign core_mem_read  = read_q;
    assign core_mem_addr  = {SIZE{row[7:0]}};
    assign core_din       = staging;
    assign busy           = (state != IDLE);

`ifdef NTT_FE_RUN_CNT_EN
    logic [31:0] run_cnt, run_cnt_inc, run_cycles_q;

    assign run_cnt_inc = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt      <= '0;
            run_cycles_q <= '0;
        end else begin
            if (state == WRITE && !more_rows) run_cnt <= '0;
            else if (state == START || state == RUN) run_cnt <= run_cnt_inc;
            // Snapshot includes the RUN cycle that sees done.
            if (state == RUN && core_done) run_cycles_q <= run_cnt_inc;
        end
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ntt_batch_frontend.sv
// Directed bench for ntt_batch_frontend: ROWS=1 instance (unit 0) and ROWS=2 instance (unit 1)
// behind a simple behavioural core memory model.
module tb_ntt_batch_frontend;
  localparam int W     = 32;
  localparam int S     = 257;
  localparam int L     = 8;
  localparam int BEATS = 33;
  localparam int DW    = W * L;
  localparam logic [W-1:0] XF_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            job_valid    [2];
  logic            job_ready    [2];
  logic [5:0]      job_mod_idx  [2];
  logic            in_valid     [2];
  logic            in_ready     [2];
  logic [DW-1:0]   in_data      [2];
  logic            out_valid    [2];
  logic            out_ready    [2];
  logic [DW-1:0]   out_data     [2];
  logic            out_last     [2];
  logic            core_start   [2];
  logic [5:0]      core_mod_idx [2];
  logic            core_mem_write [2];
  logic            core_mem_read  [2];
  logic [8*S-1:0]  core_mem_addr  [2];
  logic [W*S-1:0]  core_din     [2];
  logic [W*S-1:0]  core_dout    [2];
  logic            core_done    [2];
  logic            busy         [2];
  logic            err_mod_idx  [2];
  logic [31:0]     run_cycles   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ntt_batch_frontend #(.ROWS(g + 1)) u_dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid[g]), .job_ready(job_ready[g]), .job_mod_idx(job_mod_idx[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .out_last(out_last[g]), .core_start(core_start[g]), .core_mod_idx(core_mod_idx[g]),
      .core_mem_write(core_mem_write[g]), .core_mem_read(core_mem_read[g]),
      .core_mem_addr(core_mem_addr[g]), .core_din(core_din[g]), .core_dout(core_dout[g]),
      .core_done(core_done[g]), .busy(busy[g]), .err_mod_idx(err_mod_idx[g]),
      .run_cycles(run_cycles[g])
    );
  end

  // core model: 2-row memory per unit, read latency 1, "transform" XORs each coefficient
  logic [W*S-1:0] cmem [2][2];
  logic [7:0]     wr_addr [2][4];
  logic [7:0]     rd_addr [2][4];
  int wr_cnt [2] = '{0, 0};
  int rd_cnt [2] = '{0, 0};
  int st_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  int excl_err = 0;
  int addr_err = 0;

  function automatic logic [W*S-1:0] xf(input logic [W*S-1:0] r);
    logic [W*S-1:0] o;
    for (int k = 0; k < S; k++) o[k*W +: W] = r[k*W +: W] ^ XF_KEY;
    return o;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (int'(core_mem_write[u]) + int'(core_mem_read[u]) + int'(core_start[u]) > 1)
        excl_err <= excl_err + 1;
      if ((core_mem_write[u] || core_mem_read[u]) && core_mem_addr[u] != {S{core_mem_addr[u][7:0]}})
        addr_err <= addr_err + 1;
      if (core_mem_write[u]) begin
        cmem[u][core_mem_addr[u][0]] <= core_din[u];
        if (wr_cnt[u] < 4) wr_addr[u][wr_cnt[u]] <= core_mem_addr[u][7:0];
        wr_cnt[u] <= wr_cnt[u] + 1;
      end
      if (core_mem_read[u]) begin
        core_dout[u] <= xf(cmem[u][core_mem_addr[u][0]]);
        if (rd_cnt[u] < 4) rd_addr[u][rd_cnt[u]] <= core_mem_addr[u][7:0];
        rd_cnt[u] <= rd_cnt[u] + 1;
      end
      if (core_start[u]) st_cnt[u] <= st_cnt[u] + 1;
      if (err_mod_idx[u]) err_cnt[u] <= err_cnt[u] + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // stimulus row r, coefficient k = r*256 + k; padding lanes carry junk that must be dropped
  function automatic logic [DW-1:0] in_beat(input int r, input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int l = 0; l < L; l++)
      if (b * L + l < S) d[l*W +: W] = W'(r * 256 + b * L + l);
      else d[l*W +: W] = 32'hDEAD_0000 | W'(l);
    return d;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int r, input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int l = 0; l < L; l++)
      if (b * L + l < S) d[l*W +: W] = W'(r * 256 + b * L + l) ^ XF_KEY;
    return d;
  endfunction

  // all driver tasks start and end just after a negedge
  task automatic push_job(input int u, input int idx);
    int guard;
    guard = 0;
    job_valid[u] = 1'b1;
    job_mod_idx[u] = 6'(idx);
    while (!job_ready[u] && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) check("job_ready_timeout", DW'(job_ready[u]), DW'(1));
    @(negedge clk);
    job_valid[u] = 1'b0;
  endtask

  task automatic feed_rows(input int u, input int nrows);
    int guard;
    for (int r = 0; r < nrows; r++)
      for (int b = 0; b < BEATS; b++) begin
        guard = 0;
        in_valid[u] = 1'b1;
        in_data[u] = in_beat(r, b);
        while (!in_ready[u] && guard < 200) begin @(negedge clk); guard++; end
        if (guard >= 200) begin
          check("in_ready_timeout", DW'(in_ready[u]), DW'(1));
          in_valid[u] = 1'b0;
          return;
        end
        @(negedge clk);
      end
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_start(input int u);
    int guard;
    guard = 0;
    while (!core_start[u] && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check("start_timeout", DW'(core_start[u]), DW'(1));
  endtask

  task automatic collect(input int u, input int nrows, input bit toggle);
    logic [DW-1:0] exp_q[$];
    logic last_q[$];
    int guard, beats;
    bit ph;
    for (int r = 0; r < nrows; r++)
      for (int b = 0; b < BEATS; b++) begin
        exp_q.push_back(exp_beat(r, b));
        last_q.push_back(r == nrows - 1 && b == BEATS - 1);
      end
    guard = 0; beats = 0; ph = 1'b1;
    while (exp_q.size() > 0 && guard < 1000) begin
      out_ready[u] = toggle ? ph : 1'b1;
      ph = ~ph;
      if (out_valid[u]) begin
        check("out_data", out_data[u], exp_q[0]);
        if (out_ready[u]) begin
          check("out_last", DW'(out_last[u]), DW'(last_q[0]));
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
          beats++;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready[u] = 1'b0;
    check("beat_count", DW'(beats), DW'(nrows * BEATS));
    repeat (3) @(negedge clk);
    check("no_extra_beat", DW'(out_valid[u]), DW'(0));
  endtask

  // done is sampled 10 cycles after the START cycle; early=1 also pulses done during START
  task automatic run_job(input int u, input int idx, input int nrows, input bit toggle, input bit early);
    int rd0;
    feed_rows(u, nrows);
    wait_start(u);
    check("start_mod_idx", DW'(core_mod_idx[u]), DW'(idx));
    rd0 = rd_cnt[u];
    if (early) begin
      core_done[u] = 1'b1;
      @(negedge clk);
      core_done[u] = 1'b0;
      repeat (8) @(negedge clk);
      check("early_done_ignored", DW'(rd_cnt[u]), DW'(rd0));
      @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    core_done[u] = 1'b1;
    @(negedge clk);
    core_done[u] = 1'b0;
`ifdef NTT_FE_RUN_CNT_EN
    check("run_cycles", DW'(run_cycles[u]), DW'(11));
`else
    check("run_cycles", DW'(run_cycles[u]), DW'(0));
`endif
    collect(u, nrows, toggle);
    check("read_count", DW'(rd_cnt[u] - rd0), DW'(nrows));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, wr0, rd0, err0;
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      job_valid[u] = 1'b0; job_mod_idx[u] = '0; in_valid[u] = 1'b0; in_data[u] = '0;
      out_ready[u] = 1'b0; core_done[u] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", DW'(busy[0]), DW'(0));
    check("rst_job_ready", DW'(job_ready[0]), DW'(1));
    check("rst_out_valid", DW'(out_valid[0]), DW'(0));
    check("rst_out_last", DW'(out_last[0]), DW'(0));
    check("rst_strobes", DW'({core_start[0], core_mem_write[0], core_mem_read[0], err_mod_idx[0]}), DW'(0));
    check("rst_in_ready", DW'(in_ready[0]), DW'(0));
    check("rst_din", core_din[0][DW-1:0], DW'(0));
    check("rst_run_cycles", DW'(run_cycles[0]), DW'(0));
    reset = 1'b1;
    @(negedge clk);

    // single job, ramp data
    push_job(0, 3);
    run_job(0, 3, 1, 1'b0, 1'b0);
    check("t1_write_count", DW'(wr_cnt[0]), DW'(1));
    check("t1_write_addr", DW'(wr_addr[0][0]), DW'(0));
    check("t1_din_k0", DW'(cmem[0][0][0*W +: W]), DW'(0));
    check("t1_din_k100", DW'(cmem[0][0][100*W +: W]), DW'(100));
    check("t1_din_k256", DW'(cmem[0][0][256*W +: W]), DW'(256));
    check("t1_start_count", DW'(st_cnt[0]), DW'(1));
    check("t1_busy_after", DW'(busy[0]), DW'(0));

    // out-of-range modulus index
    st0 = st_cnt[0]; wr0 = wr_cnt[0];
    job_valid[0] = 1'b1; job_mod_idx[0] = 6'd40;
    check("t2_ready_before", DW'(job_ready[0]), DW'(1));
    @(negedge clk);
    job_valid[0] = 1'b0;
    check("t2_err_pulse", DW'(err_mod_idx[0]), DW'(1));
    check("t2_ready_kept", DW'(job_ready[0]), DW'(1));
    @(negedge clk);
    check("t2_err_single", DW'(err_mod_idx[0]), DW'(0));
    repeat (5) @(negedge clk);
    check("t2_busy", DW'(busy[0]), DW'(0));
    check("t2_no_core", DW'(st_cnt[0] - st0 + wr_cnt[0] - wr0), DW'(0));

    // FIFO fill while job 0 waits in LOAD, then in-order execution
    err0 = err_cnt[0];
    push_job(0, 5);
    push_job(0, 39);
    push_job(0, 0);
    push_job(0, 7);
    push_job(0, 12);
    check("t3_full", DW'(job_ready[0]), DW'(0));
    job_valid[0] = 1'b1; job_mod_idx[0] = 6'd21;
    repeat (3) @(negedge clk);
    check("t3_full_hold", DW'(job_ready[0]), DW'(0));
    fork
      push_job(0, 21);
      run_job(0, 5, 1, 1'b0, 1'b0);
    join
    run_job(0, 39, 1, 1'b1, 1'b0);
    run_job(0, 0, 1, 1'b0, 1'b1);
    run_job(0, 7, 1, 1'b0, 1'b0);
    run_job(0, 12, 1, 1'b0, 1'b0);
    run_job(0, 21, 1, 1'b1, 1'b0);
    check("t3_no_err", DW'(err_cnt[0] - err0), DW'(0));
    check("t3_idle", DW'(busy[0]), DW'(0));

    // two-row instance
    push_job(1, 9);
    run_job(1, 9, 2, 1'b1, 1'b0);
    check("t5_write_count", DW'(wr_cnt[1]), DW'(2));
    check("t5_write_addr0", DW'(wr_addr[1][0]), DW'(0));
    check("t5_write_addr1", DW'(wr_addr[1][1]), DW'(1));
    check("t5_read_addr0", DW'(rd_addr[1][0]), DW'(0));
    check("t5_read_addr1", DW'(rd_addr[1][1]), DW'(1));
    check("t5_start_count", DW'(st_cnt[1]), DW'(1));

    // reset while the core runs
    push_job(0, 17);
    feed_rows(0, 1);
    wait_start(0);
    repeat (3) @(negedge clk);
    rd0 = rd_cnt[0]; st0 = st_cnt[0]; wr0 = wr_cnt[0];
    reset = 1'b0;
    #1;
    check("t6_busy", DW'(busy[0]), DW'(0));
    check("t6_out", DW'({out_valid[0], out_last[0]}), DW'(0));
    check("t6_strobes", DW'({core_start[0], core_mem_write[0], core_mem_read[0]}), DW'(0));
    check("t6_run_cycles", DW'(run_cycles[0]), DW'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    core_done[0] = 1'b1;
    @(negedge clk);
    core_done[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_done_ignored", DW'(rd_cnt[0] - rd0 + st_cnt[0] - st0 + wr_cnt[0] - wr0), DW'(0));
    check("t6_idle", DW'({busy[0], out_valid[0]}), DW'(0));
    push_job(0, 2);
    run_job(0, 2, 1, 1'b0, 1'b0);

    check("strobe_exclusive", DW'(excl_err), DW'(0));
    check("addr_replicated", DW'(addr_err), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
